// File: rtl/imm_encoder.sv
// Two-stage RISC-V instruction assembler: S1 latches fields and range-checks imm, S2 holds the word.
// Latency 2 cycles, 1 word/cycle; each stage stalls only when full and its downstream is stalled.
module imm_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr,
    output logic        err,
    output logic [15:0] enc_count,
    output logic [15:0] err_count
);
    localparam logic [2:0]  FMT_I = 3'b000;
    localparam logic [2:0]  FMT_U = 3'b001;
    localparam logic [2:0]  FMT_B = 3'b010;
    localparam logic [2:0]  FMT_J = 3'b011;
    localparam logic [2:0]  FMT_S = 3'b100;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        s1_valid;
    logic [2:0]  s1_fmt;
    logic [6:0]  s1_opcode;
    logic [2:0]  s1_funct3;
    logic [4:0]  s1_rd;
    logic [4:0]  s1_rs1;
    logic [4:0]  s1_rs2;
    logic [31:0] s1_imm;
    logic        s1_bad;
    logic        s2_valid;
    logic        s1_ready;
    logic        s2_ready;
    logic        bad;
    logic [31:0] word;

    assign s2_ready  = !s2_valid || out_ready;
    assign s1_ready  = !s1_valid || s2_ready;
    assign in_ready  = s1_ready;
    assign out_valid = s2_valid;

    // Bits above the field must all replicate the field's sign bit.
    always_comb begin
        bad = 1'b0;
        case (fmt)
            FMT_I, FMT_S: bad = (imm[31:11] != {21{imm[11]}});
            FMT_B:        bad = (imm[31:12] != {20{imm[12]}}) || imm[0];
            FMT_U:        bad = (imm[11:0] != 12'd0);
            FMT_J:        bad = (imm[31:20] != {12{imm[20]}}) || imm[0];
            default:      bad = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_fmt    <= 3'd0;
            s1_opcode <= 7'd0;
            s1_funct3 <= 3'd0;
            s1_rd     <= 5'd0;
            s1_rs1    <= 5'd0;
            s1_rs2    <= 5'd0;
            s1_imm    <= 32'd0;
            s1_bad    <= 1'b0;
        end else if (s1_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_fmt    <= fmt;
                s1_opcode <= opcode;
                s1_funct3 <= funct3;
                s1_rd     <= rd;
                s1_rs1    <= rs1;
                s1_rs2    <= rs2;
                s1_imm    <= imm;
                s1_bad    <= bad;
            end
        end
    end

    always_comb begin
        word = NOP;
        case (s1_fmt)
            FMT_I: word = {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
            FMT_S: word = {s1_imm[11:5], s1_rs2, s1_rs1, s1_funct3, s1_imm[4:0], s1_opcode};
            FMT_B: word = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_funct3,
                           s1_imm[4:1], s1_imm[11], s1_opcode};
            FMT_U: word = {s1_imm[31:12], s1_rd, s1_opcode};
            FMT_J: word = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_rd, s1_opcode};
            default: word = NOP;
        endcase
        if (s1_bad)
            word = NOP;
    end

    // S2 only reloads when it can hand off, so instr/err stay frozen under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            instr     <= 32'd0;
            err       <= 1'b0;
            enc_count <= 16'd0;
            err_count <= 16'd0;
        end else begin
            if (s2_ready) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    instr <= word;
                    err   <= s1_bad;
                end
            end
            if (s2_valid && out_ready) begin
                if (err) begin
                    if (err_count != 16'hFFFF)
                        err_count <= err_count + 16'd1;
                end else if (enc_count != 16'hFFFF) begin
                    enc_count <= enc_count + 16'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_imm_encoder.sv
// Directed self-checking bench for imm_encoder with hand-computed instruction words.
module tb_imm_encoder;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic        err;
    logic [15:0] enc_count, err_count;

    int n_chk = 0;
    int n_err = 0;
    int acc_cnt = 0;
    int del_cnt = 0;
    logic capture = 1'b1;
    logic [32:0] q[$];

    imm_encoder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .funct3(funct3), .rd(rd), .rs1(rs1), .rs2(rs2),
        .imm(imm), .out_valid(out_valid), .out_ready(out_ready), .instr(instr),
        .err(err), .enc_count(enc_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Handshake monitor: sees pre-edge values of registered outputs.
    always @(posedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready)
                acc_cnt++;
            if (out_valid && out_ready) begin
                del_cnt++;
                if (capture)
                    q.push_back({err, instr});
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_req(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                           input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                           input logic [31:0] im);
        fmt = f; opcode = op; funct3 = f3; rd = d; rs1 = s1; rs2 = s2; imm = im;
    endtask

    task automatic single_req(input string tag, input logic [31:0] exp_instr);
        @(negedge clk);
        in_valid = 1'b1;
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_lat1"}, {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check({tag, "_lat2"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_instr"}, instr, exp_instr);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int base_acc, base_del;
        logic seen;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        set_req(3'd0, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        repeat (3) @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_enc_count", {16'd0, enc_count}, 32'd0);
        check("rst_err_count", {16'd0, err_count}, 32'd0);
        rst = 1'b0;
        #1;
        check("rel_in_ready", {31'd0, in_ready}, 32'd1);

        // I, U, B encodings; rs2 set on the I request to confirm it is ignored
        set_req(3'b000, 7'b0000011, 3'b010, 5'd5, 5'd2, 5'd31, -32'sd4);
        single_req("I", 32'hFFC12283);
        set_req(3'b001, 7'b0110111, 3'b101, 5'd1, 5'd7, 5'd9, 32'h12345000);
        single_req("U", 32'h123450B7);
        set_req(3'b010, 7'b1100011, 3'b000, 5'd17, 5'd1, 5'd2, 32'd8);
        single_req("B", 32'h00208463);
        check("enc_after_good", {16'd0, enc_count}, 32'd3);

        // Error stream: misaligned J, out-of-range I, invalid fmt
        q.delete();
        @(negedge clk);
        set_req(3'b011, 7'b1101111, 3'd0, 5'd1, 5'd0, 5'd0, 32'd3);
        in_valid = 1'b1;
        @(negedge clk);
        set_req(3'b000, 7'b0010011, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
        @(negedge clk);
        set_req(3'b111, 7'b0010011, 3'd0, 5'd1, 5'd0, 5'd0, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("errs_count_q", q.size(), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < q.size()) begin
                check("errs_instr", q[i][31:0], 32'h00000013);
                check("errs_err", {31'd0, q[i][32]}, 32'd1);
            end
        end
        check("errs_err_count", {16'd0, err_count}, 32'd3);
        check("errs_enc_count", {16'd0, enc_count}, 32'd3);

        // Backpressure: three back-to-back offers with out_ready low
        q.delete();
        @(negedge clk);
        out_ready = 1'b0;
        base_acc = acc_cnt;
        set_req(3'b000, 7'b0010011, 3'd0, 5'd1, 5'd0, 5'd31, 32'd1);
        in_valid = 1'b1;
        @(negedge clk);
        set_req(3'b000, 7'b0010011, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2);
        @(negedge clk);
        set_req(3'b000, 7'b0010011, 3'd0, 5'd1, 5'd0, 5'd0, 32'd3);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_instr_stable", instr, 32'h00100093);
        end
        check("bp_accepted", acc_cnt - base_acc, 32'd2);
        check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        check("bp_out_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (acc_cnt - base_acc >= 3) break;
        end
        in_valid = 1'b0;
        check("bp_accept_third", acc_cnt - base_acc, 32'd3);
        repeat (5) @(negedge clk);
        check("bp_delivered", q.size(), 32'd3);
        if (q.size() >= 3) begin
            check("bp_word0", q[0][31:0], 32'h00100093);
            check("bp_word1", q[1][31:0], 32'h00200093);
            check("bp_word2", q[2][31:0], 32'h00300093);
        end

        // Reset with both stages full
        @(negedge clk);
        out_ready = 1'b0;
        set_req(3'b000, 7'b0010011, 3'd0, 5'd1, 5'd0, 5'd0, 32'd4);
        in_valid = 1'b1;
        @(negedge clk);
        set_req(3'b000, 7'b0010011, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        @(negedge clk);
        in_valid = 1'b0;
        check("full_out_valid", {31'd0, out_valid}, 32'd1);
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_enc", {16'd0, enc_count}, 32'd0);
        check("mid_rst_errc", {16'd0, err_count}, 32'd0);
        check("mid_rst_instr", instr, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        q.delete();
        base_del = del_cnt;
        #1;
        check("mid_rel_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (5) @(negedge clk);
        check("no_stale_words", del_cnt - base_del, 32'd0);

        // Saturation: 65535 good deliveries, then one more
        capture = 1'b0;
        seen = 1'b0;
        base_acc = acc_cnt;
        base_del = del_cnt;
        set_req(3'b000, 7'b0010011, 3'd0, 5'd1, 5'd0, 5'd0, 32'd1);
        in_valid = 1'b1;
        for (int k = 0; k < 70000; k++) begin
            @(negedge clk);
            if (acc_cnt - base_acc >= 65536) in_valid = 1'b0;
            if (!seen && (del_cnt - base_del == 65535)) begin
                seen = 1'b1;
                check("sat_at_65535", {16'd0, enc_count}, 32'h0000FFFF);
            end
            if (del_cnt - base_del >= 65536) break;
        end
        in_valid = 1'b0;
        check("sat_reached_65535", {31'd0, seen}, 32'd1);
        check("sat_deliveries", del_cnt - base_del, 32'd65536);
        repeat (3) @(negedge clk);
        check("sat_enc_count", {16'd0, enc_count}, 32'h0000FFFF);
        check("sat_err_count", {16'd0, err_count}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: in_valid  input  1  request fields valid.
REQ-004 SHALL have port: in_ready  output  1  encoder accepts request this cycle.
REQ-005 SHALL have port: fmt  input  3  000 I, 001 U, 010 B, 011 J, 100 S; 101-111 invalid.
REQ-006 SHALL have ports: opcode  input  7; funct3  input  3; rd, rs1, rs2  input  5 each: instruction fields.
REQ-007 SHALL have port: imm  input  32  full two's-complement immediate value, not pre-shifted.
REQ-008 SHALL have port: out_valid  output  1  encoded word valid.
REQ-009 SHALL have port: out_ready  input  1  consumer accepts word.
REQ-010 SHALL have port: instr  output  32  encoded instruction word.
REQ-011 SHALL have port: err  output  1  request not encodable; qualified by out_valid.
REQ-012 SHALL have ports: enc_count, err_count  output  16 each  handshake statistics.

Function
REQ-013 SHALL accept a request when in_valid && in_ready.
REQ-014 SHALL deliver a word when out_valid && out_ready.
REQ-015 SHALL be a 2-stage pipeline: S1 registers fields and computes range check; S2 holds the assembled word and err.
REQ-016 SHALL give latency 2 cycles from acceptance to out_valid when out_ready is held 1, with throughput 1 word/cycle.
REQ-017 SHALL advance each stage when it is empty or its downstream stage advances; in_ready = !S1_valid || S1 advancing (combinational on out_ready).
REQ-018 SHALL under backpressure hold instr/err stable while out_valid && !out_ready, drop nothing, duplicate nothing, and preserve order.
REQ-019 SHALL encode I: instr = {imm[11:0], rs1, funct3, rd, opcode}; legal range -2048..2047.
REQ-020 SHALL encode S: instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}; legal range -2048..2047.
REQ-021 SHALL encode B: instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}; legal range -4096..4094, imm[0] must be 0.
REQ-022 SHALL encode U: instr = {imm[31:12], rd, opcode}; imm[11:0] must be 0.
REQ-023 SHALL encode J: instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}; legal range -1048576..1048574, imm[0] must be 0.
REQ-024 SHALL evaluate range checks on the signed 32-bit imm; the upper bits must equal the sign bit of the field.
REQ-025 SHALL, for an out-of-range, misaligned, or invalid-fmt request, output err=1 and instr=32'h00000013 (canonical NOP).
REQ-026 SHALL ignore fields unused by the format; they do not affect instr.
REQ-027 SHALL increment enc_count on each delivery with err=0 and err_count on each delivery with err=1; both saturate at 16'hFFFF.
REQ-028 SHALL ignore in_valid while in_ready=0; field changes while not accepted have no effect.

Reset
REQ-029 SHALL, while rst=1, asynchronously force S1_valid=0, S2_valid=0, out_valid=0, err=0, instr=32'h0, enc_count=0, err_count=0.
REQ-030 SHALL discard requests in flight when reset is asserted mid-operation; none appear after release.
REQ-031 SHALL drive in_ready=1 from the first cycle after rst deasserts.

Verification
REQ-032 SHALL verify I-type: fmt=000, opcode=0000011, funct3=010, rd=5, rs1=2, imm=-4 -> instr=0xFFC12283, err=0, two cycles after acceptance.
REQ-033 SHALL verify U and B types: U fmt=001, opcode=0110111, rd=1, imm=0x12345000 -> 0x123450B7; B fmt=010, opcode=1100011, funct3=000, rs1=1, rs2=2, imm=8 -> 0x00208463.
REQ-034 SHALL verify errors: J imm=3, then I imm=2048, then fmt=111 -> three words instr=0x00000013, err=1; err_count=3, enc_count unchanged.
REQ-035 SHALL verify backpressure: hold out_ready=0 and offer 3 back-to-back requests -> exactly 2 accepted, in_ready=0, instr stable; release -> 3 words delivered in order.
REQ-036 SHALL verify reset mid-stream: assert rst with both stages full -> out_valid=0 and counters=0 immediately; after release, no stale word is delivered.
REQ-037 SHALL verify saturation: preload 65535 good deliveries, then 1 more -> enc_count=0xFFFF.
